prime_test_sequencer: RTL and testbench
=======================================

// Module: prime_test_sequencer
// PURPOSE
//  Control FSM that runs an 8-bit trial-division primality test on the shared datapath.
//  Drives seven one-hot control strobes (ld_e, ld_a, ld_k, sub_a, inc_k, set_p, clr_p) into the datapath.
//  Reads back the datapath registers E (copy of N), A (working remainder) and K (divisor).
//  Sits beside the datapath under the top level and replaces the free-running FSM with a start/busy/done handshake.
// PARAMETERS
//  W           8     datapath width of E, A, K
//  MAX_CYCLES  4095  watchdog limit per run, counted in cycles from leaving IDLE
// PORTS
//  Clk    in   1  system clock, rising edge; the only clock in the block
//  Rst_n  in   1  asynchronous active-low reset
//  Start  in   1  raw level from a pushbutton; synchronised internally, acts on its rising edge
//  E      in   W  datapath register holding N
//  A      in   W  datapath working remainder
//  K      in   W  datapath trial divisor
//  Ctrl   out  7  {clr_p,set_p,inc_k,sub_a,ld_k,ld_a,ld_e}; registered; at most one bit high
//  Busy   out  1  high from leaving IDLE until a terminal state is reached
//  Done   out  1  one-cycle pulse when a result is final
//  Err    out  1  sticky; watchdog expired; cleared by the next accepted Start
// BEHAVIOUR
//  Reset: state=IDLE; Ctrl, Busy, Done, Err = 0; watchdog = 0.
//  Start path: 2-FF synchroniser followed by rising-edge detect. A held-high Start yields exactly one run.
//  Start edges that arrive while Busy are ignored.
//  States and transitions (one cycle each; Ctrl is decoded from next-state and registered):
//   IDLE  : on start edge -> LOAD_E; Busy<=1; Err<=0.
//   LOAD_E: ld_e.  -> LOAD_K.
//   LOAD_K: ld_k (K<=2).  -> SMALL.
//   SMALL : E<2 -> COMP; E==2 -> PRIME; else -> OUTER.
//   OUTER : K>=E -> PRIME; else -> LOAD_A.
//   LOAD_A: ld_a (A<=E).  -> SUB.
//   SUB   : A>=K -> sub_a, stay in SUB; else -> TEST.
//   TEST  : A==0 -> COMP; else -> INC_K.
//   INC_K : inc_k.  -> OUTER.
//   PRIME : set_p; Done pulse; Busy<=0.  -> IDLE.
//   COMP  : clr_p; Done pulse; Busy<=0.  -> IDLE.
//  Comparisons are unsigned W-bit. The sequencer never commands inc_k when K==2^W-1, because OUTER exits first since E<=K.
//  Watchdog: counts while Busy. At MAX_CYCLES it forces clr_p, sets Err and pulses Done, then returns to IDLE.
//  Reset mid-run: immediate return to IDLE. Datapath register contents are undefined until the next run's LOAD_E.
//  Datapath values are sampled one cycle after the strobe that updates them; no combinational Ctrl->status loop.
// CONFIGURATION
//  SEQ_TRACE_EN defined:
//   - adds ports Dbg_state (out, 4, current state code) and Dbg_cycles (out, 12, cycle count of the last run);
//   - Dbg_cycles latches on Done and resets to 0.
//  SEQ_TRACE_EN undefined:
//   - neither port exists;
//   - no cycle-latch register is built.
// STRUCTURE
//  Shared include seq_defs.vh holds:
//   - 4-bit state codes;
//   - Ctrl bit indices (CTRL_LD_E..CTRL_CLR_P);
//   - W default.
//  The datapath includes the same Ctrl indices.
//  One sub-module, start_edge_sync (2-FF synchroniser + rising-edge pulse, async active-low reset).
//  Next-state/Ctrl decode and the watchdog counter stay in the top file.
// TESTING
//  1. Reset release with Start=0 -> Ctrl=0, Busy=0, Done=0, Err=0 for 20 cycles.
//  2. N=7 (E=7 via model), one Start edge:
//     -> K sweeps 2..6, no A==0 in TEST, set_p asserted once, Done pulses once, Busy falls.
//  3. N=9 -> exit at K=3 with A==0; clr_p asserted, Done pulses once, inc_k seen exactly once.
//  4. N=0, N=1, N=2:
//     -> COMP, COMP, PRIME respectively;
//     -> Done exactly 4 cycles after the synchronised Start edge (LOAD_E, LOAD_K, SMALL, terminal).
//  5. Start held high 500 cycles with N=251 -> exactly one run, PRIME, Err=0; Start pulses mid-run ignored.
//  6. Reset mid-SUB, and stuck A model with MAX_CYCLES=64:
//     -> reset gives immediate IDLE with zero outputs;
//     -> stuck model gives Err=1 plus a Done pulse at cycle 64; next Start clears Err.

Source files
------------

// File: rtl/prime_test_sequencer_pkg.sv
// Shared definitions for the primality sequencer: state codes, Ctrl bit indices and the default width.
package prime_test_sequencer_pkg;

    localparam int W_DEFAULT = 8;
    localparam int CTRL_W    = 7;

    localparam int CTRL_LD_E  = 0;
    localparam int CTRL_LD_A  = 1;
    localparam int CTRL_LD_K  = 2;
    localparam int CTRL_SUB_A = 3;
    localparam int CTRL_INC_K = 4;
    localparam int CTRL_SET_P = 5;
    localparam int CTRL_CLR_P = 6;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD_E = 4'd1,
        ST_LOAD_K = 4'd2,
        ST_SMALL  = 4'd3,
        ST_OUTER  = 4'd4,
        ST_LOAD_A = 4'd5,
        ST_SUB    = 4'd6,
        ST_TEST   = 4'd7,
        ST_INC_K  = 4'd8,
        ST_PRIME  = 4'd9,
        ST_COMP   = 4'd10
    } state_t;

    function automatic logic [CTRL_W-1:0] ctrl_bit(input int idx);
        logic [CTRL_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/prime_test_sequencer_start_edge_sync.sv
// Two-flop synchroniser for the raw Start level followed by a rising-edge pulse.
module start_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);

    logic [1:0] sync_reg;
    logic       prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], raw};
            prev_reg <= sync_reg[1];
        end
    end

    assign pulse = sync_reg[1] & ~prev_reg;

endmodule

// File: rtl/prime_test_sequencer.sv
// Trial-division primality sequencer with start/busy/done handshake and watchdog.
// Optional SEQ_TRACE_EN adds dbg_state and dbg_cycles debug ports.
module prime_test_sequencer
    import prime_test_sequencer_pkg::*;
#(
    parameter int W          = W_DEFAULT,
    parameter int MAX_CYCLES = 4095
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [W-1:0]      e,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      k,
    output logic [CTRL_W-1:0] ctrl,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef SEQ_TRACE_EN
    ,
    output logic [3:0]        dbg_state,
    output logic [11:0]       dbg_cycles
`endif
);

    localparam int WD_W = $clog2(MAX_CYCLES + 1);

    state_t            state_reg, state_next;
    logic [CTRL_W-1:0] ctrl_reg, ctrl_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic [WD_W-1:0]   wd_reg;
    logic              start_pulse;
    logic              start_accept;
    logic              sub_issue;
    logic              wd_fire;

    start_edge_sync u_start_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (start),
        .pulse (start_pulse)
    );

    assign start_accept = (state_reg == ST_IDLE) && start_pulse;
    assign wd_fire      = busy_reg && (wd_reg == WD_W'(MAX_CYCLES - 1));

    always_comb begin
        state_next = state_reg;
        sub_issue  = 1'b0;
        case (state_reg)
            ST_IDLE:   if (start_accept) state_next = ST_LOAD_E;
            ST_LOAD_E: state_next = ST_LOAD_K;
            ST_LOAD_K: state_next = ST_SMALL;
            ST_SMALL: begin
                if (e < W'(2))       state_next = ST_COMP;
                else if (e == W'(2)) state_next = ST_PRIME;
                else                 state_next = ST_OUTER;
            end
            ST_OUTER:  state_next = (k >= e) ? ST_PRIME : ST_LOAD_A;
            ST_LOAD_A: state_next = ST_SUB;
            ST_SUB: begin
                // A subtract issued last cycle has not reached A yet; wait one cycle before comparing.
                if (ctrl_reg[CTRL_SUB_A]) begin
                    state_next = ST_SUB;
                end else if (a >= k) begin
                    state_next = ST_SUB;
                    sub_issue  = 1'b1;
                end else begin
                    state_next = ST_TEST;
                end
            end
            ST_TEST:   state_next = (a == '0) ? ST_COMP : ST_INC_K;
            ST_INC_K:  state_next = ST_OUTER;
            ST_PRIME:  state_next = ST_IDLE;
            ST_COMP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase

        if (wd_fire) state_next = ST_COMP;

        ctrl_next = '0;
        case (state_next)
            ST_LOAD_E: ctrl_next = ctrl_bit(CTRL_LD_E);
            ST_LOAD_K: ctrl_next = ctrl_bit(CTRL_LD_K);
            ST_LOAD_A: ctrl_next = ctrl_bit(CTRL_LD_A);
            ST_SUB:    ctrl_next = sub_issue ? ctrl_bit(CTRL_SUB_A) : '0;
            ST_INC_K:  ctrl_next = ctrl_bit(CTRL_INC_K);
            ST_PRIME:  ctrl_next = ctrl_bit(CTRL_SET_P);
            ST_COMP:   ctrl_next = ctrl_bit(CTRL_CLR_P);
            default:   ctrl_next = '0;
        endcase

        done_next = (state_next == ST_PRIME) || (state_next == ST_COMP);
        busy_next = !done_next && (state_next != ST_IDLE);

        if (wd_fire)           err_next = 1'b1;
        else if (start_accept) err_next = 1'b0;
        else                   err_next = err_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            ctrl_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            wd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= ctrl_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            if (start_accept)  wd_reg <= '0;
            else if (busy_reg) wd_reg <= wd_reg + WD_W'(1);
        end
    end

    assign ctrl = ctrl_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign err  = err_reg;

`ifdef SEQ_TRACE_EN
    logic [11:0] cycles_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         cycles_reg <= '0;
        else if (done_next) cycles_reg <= 12'(wd_reg) + 12'd1;
    end

    assign dbg_state  = state_reg;
    assign dbg_cycles = cycles_reg;
`endif

endmodule

// File: tb/tb_prime_test_sequencer.sv
// Directed bench: a normal sequencer on a behavioural datapath, plus a short-watchdog one on a datapath whose A never changes.
module tb_prime_test_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_main = 1'b0;
    logic       start_wd = 1'b0;
    logic [7:0] n_main = 8'd0;
    logic [7:0] n_wd = 8'd0;

    logic [7:0] e_m, a_m, k_m, e_w, a_w, k_w;
    logic       p_m, p_w;
    logic [6:0] ctrl_main, ctrl_wd;
    logic       busy_main, done_main, err_main;
    logic       busy_wd, done_wd, err_wd;

    int n_vec  = 0;
    int n_miss = 0;
    int inc_cnt = 0, set_cnt = 0, clr_cnt = 0, done_cnt = 0, rise_cnt = 0, oh_viol = 0;
    logic busy_prev = 1'b0;

    always #5 clk = ~clk;

`ifdef SEQ_TRACE_EN
    logic [3:0]  dbg_state_m, dbg_state_w;
    logic [11:0] dbg_cycles_m, dbg_cycles_w;
`endif

    prime_test_sequencer #(.W(8), .MAX_CYCLES(4095)) dut_main (
        .clk(clk), .rst_n(rst_n), .start(start_main),
        .e(e_m), .a(a_m), .k(k_m),
        .ctrl(ctrl_main), .busy(busy_main), .done(done_main), .err(err_main)
`ifdef SEQ_TRACE_EN
        , .dbg_state(dbg_state_m), .dbg_cycles(dbg_cycles_m)
`endif
    );

    prime_test_sequencer #(.W(8), .MAX_CYCLES(64)) dut_wd (
        .clk(clk), .rst_n(rst_n), .start(start_wd),
        .e(e_w), .a(a_w), .k(k_w),
        .ctrl(ctrl_wd), .busy(busy_wd), .done(done_wd), .err(err_wd)
`ifdef SEQ_TRACE_EN
        , .dbg_state(dbg_state_w), .dbg_cycles(dbg_cycles_w)
`endif
    );

    // Behavioural datapaths: each strobe takes effect on the edge after it is presented.
    always @(posedge clk) begin
        if (ctrl_main[0]) e_m <= n_main;
        if (ctrl_main[1]) a_m <= e_m;
        if (ctrl_main[2]) k_m <= 8'd2;
        if (ctrl_main[3]) a_m <= a_m - k_m;
        if (ctrl_main[4]) k_m <= k_m + 8'd1;
        if (ctrl_main[5]) p_m <= 1'b1;
        if (ctrl_main[6]) p_m <= 1'b0;
        if (ctrl_wd[0]) e_w <= n_wd;
        if (ctrl_wd[1]) a_w <= e_w;
        if (ctrl_wd[2]) k_w <= 8'd2;
        if (ctrl_wd[4]) k_w <= k_w + 8'd1;
        if (ctrl_wd[5]) p_w <= 1'b1;
        if (ctrl_wd[6]) p_w <= 1'b0;
    end

    always @(negedge clk) begin
        if (ctrl_main[4]) inc_cnt++;
        if (ctrl_main[5]) set_cnt++;
        if (ctrl_main[6]) clr_cnt++;
        if (done_main) done_cnt++;
        if (busy_main && !busy_prev) rise_cnt++;
        busy_prev = busy_main;
        if ($countones(ctrl_main) > 1 || $countones(ctrl_wd) > 1) oh_viol++;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // One run: raise Start, release after `hold` cycles, optionally re-pulse it mid-run.
    // lat is the number of cycles from Busy first seen high to Done seen high.
    task automatic run_seq(input bit sel, input logic [7:0] n, input int hold, input bit poke,
                           output int lat, output logic [6:0] cd, output logic ed);
        int t;
        int b;
        t = 0; b = -1; lat = -1; cd = '0; ed = 1'b0;
        if (sel) begin n_wd = n; start_wd = 1'b1; end
        else     begin n_main = n; start_main = 1'b1; end
        while (t < 6000 && lat < 0) begin
            @(negedge clk);
            t++;
            if (t == hold) begin start_main = 1'b0; start_wd = 1'b0; end
            if (poke && t == 1000) start_main = 1'b1;
            if (poke && t == 1004) start_main = 1'b0;
            if (b < 0 && (sel ? busy_wd : busy_main)) b = t;
            if (b >= 0 && (sel ? done_wd : done_main)) begin
                lat = t - b;
                cd  = sel ? ctrl_wd : ctrl_main;
                ed  = sel ? err_wd : err_main;
            end
        end
        start_main = 1'b0;
        start_wd   = 1'b0;
        check_vec("run_completed", (lat >= 0) ? 32'd1 : 32'd0, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    int lat;
    logic [6:0] cd;
    logic ed;
    int s_inc, s_set, s_clr, s_done, s_rise, t;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_vec("reset_idle_outputs", {ctrl_main, busy_main, done_main, err_main}, 32'd0);
        end

        // N=7: prime after K sweeps 2..6
        s_inc = inc_cnt; s_set = set_cnt; s_done = done_cnt;
        run_seq(1'b0, 8'd7, 2, 1'b0, lat, cd, ed);
        check_vec("n7_ctrl_at_done", cd, 32'h20);
        check_vec("n7_p", p_m, 1'b1);
        check_vec("n7_inc_k_count", inc_cnt - s_inc, 32'd5);
        check_vec("n7_set_p_count", set_cnt - s_set, 32'd1);
        check_vec("n7_done_count", done_cnt - s_done, 32'd1);
        check_vec("n7_final_k", k_m, 32'd7);
        check_vec("n7_busy_low", busy_main, 1'b0);

        // N=9: composite found at K=3
        s_inc = inc_cnt; s_clr = clr_cnt; s_done = done_cnt;
        run_seq(1'b0, 8'd9, 2, 1'b0, lat, cd, ed);
        check_vec("n9_ctrl_at_done", cd, 32'h40);
        check_vec("n9_p", p_m, 1'b0);
        check_vec("n9_inc_k_count", inc_cnt - s_inc, 32'd1);
        check_vec("n9_clr_p_count", clr_cnt - s_clr, 32'd1);
        check_vec("n9_done_count", done_cnt - s_done, 32'd1);
        check_vec("n9_final_k", k_m, 32'd3);
        check_vec("n9_final_a", a_m, 32'd0);

        // Small values resolve in SMALL: LOAD_E, LOAD_K, SMALL, terminal
        run_seq(1'b0, 8'd0, 2, 1'b0, lat, cd, ed);
        check_vec("n0_latency", lat, 32'd3);
        check_vec("n0_ctrl_at_done", cd, 32'h40);
        run_seq(1'b0, 8'd1, 2, 1'b0, lat, cd, ed);
        check_vec("n1_latency", lat, 32'd3);
        check_vec("n1_ctrl_at_done", cd, 32'h40);
        run_seq(1'b0, 8'd2, 2, 1'b0, lat, cd, ed);
        check_vec("n2_latency", lat, 32'd3);
        check_vec("n2_ctrl_at_done", cd, 32'h20);
        check_vec("n2_p", p_m, 1'b1);

        // N=251 with Start held 500 cycles and a pulse mid-run
        s_done = done_cnt; s_rise = rise_cnt;
        run_seq(1'b0, 8'd251, 500, 1'b1, lat, cd, ed);
        repeat (20) @(negedge clk);
        check_vec("n251_ctrl_at_done", cd, 32'h20);
        check_vec("n251_err_at_done", ed, 1'b0);
        check_vec("n251_p", p_m, 1'b1);
        check_vec("n251_single_run", rise_cnt - s_rise, 32'd1);
        check_vec("n251_single_done", done_cnt - s_done, 32'd1);

        // Reset while subtracting
        n_main = 8'd9;
        start_main = 1'b1;
        t = 0;
        while (t < 100 && ctrl_main != 7'h08) begin
            @(negedge clk);
            t++;
        end
        start_main = 1'b0;
        check_vec("reached_sub", ctrl_main, 32'h08);
        #2 rst_n = 1'b0;
        #1 check_vec("midrun_reset_outputs", {ctrl_main, busy_main, done_main, err_main}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_vec("after_reset_idle", {ctrl_main, busy_main, done_main, err_main}, 32'd0);

        // Stuck-A datapath on a 64-cycle watchdog
        run_seq(1'b1, 8'd9, 2, 1'b0, lat, cd, ed);
        check_vec("wd_latency", lat, 32'd64);
        check_vec("wd_ctrl_at_done", cd, 32'h40);
        check_vec("wd_err_at_done", ed, 1'b1);
        check_vec("wd_err_sticky", err_wd, 1'b1);
        run_seq(1'b1, 8'd2, 2, 1'b0, lat, cd, ed);
        check_vec("wd_err_cleared", err_wd, 1'b0);
        check_vec("wd_rerun_ctrl_at_done", cd, 32'h20);

        check_vec("ctrl_onehot_violations", oh_viol, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
